pending_encoder_32x5: RTL

Sequential 32-to-5 encoder. It is the inverse of the 5x32 enabled decoder used for register and line selection in the CPU datapath. It captures a 32-bit multi-hot request vector (pending exceptions, dirty registers, write-back flags) and emits the 5-bit index of every set bit, lowest index first, over a valid/ready handshake. A done pulse marks the end of each vector.

---
 rtl/pending_encoder_32x5.sv | 112 +++++++++++
 1 files changed

// File: rtl/pending_encoder_32x5.sv
// Sequential 32-to-5 pending encoder.
// Captures a multi-hot request vector and emits the index of each set bit,
// lowest first, over a valid/ready handshake. A registered done pulse marks
// the end of each vector, including a loaded all-zero vector.
module pending_encoder_32x5 #(
   parameter int INPUT_WIDTH = 32,
   parameter int INDEX_WIDTH = $clog2(INPUT_WIDTH)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   load_i,
   input  logic [INPUT_WIDTH-1:0] vec_i,
   input  logic                   flush_i,
   input  logic                   ready_i,
   output logic                   valid_o,
   output logic [INDEX_WIDTH-1:0] idx_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [INDEX_WIDTH:0]   remaining_o
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [INPUT_WIDTH-1:0] pending_q, pending_d;
   logic                   done_q, done_d;

   logic [INDEX_WIDTH-1:0] lowestIdx;
   logic [INDEX_WIDTH:0]   popCount;
   logic                   emitting;

   assign emitting = (state_q == EMIT);

   // Priority encoder: scanning from the top lets the lowest set bit win.
   always_comb begin
      lowestIdx = '0;
      for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            lowestIdx = INDEX_WIDTH'(i);
         end
      end
   end

   // Population count of the bits still waiting to be emitted.
   always_comb begin
      popCount = '0;
      for (int i = 0; i < INPUT_WIDTH; i++) begin
         popCount = popCount + (INDEX_WIDTH + 1)'(pending_q[i]);
      end
   end

   // Next-state logic; flush overrides load and handshake, and a handshake
   // clears the lowest set bit with the x & (x-1) trick.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      done_d    = 1'b0;
      if (flush_i) begin
         state_d   = IDLE;
         pending_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_i) begin
                  if (vec_i != '0) begin
                     pending_d = vec_i;
                     state_d   = EMIT;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            EMIT: begin
               if (ready_i) begin
                  pending_d = pending_q & (pending_q - INPUT_WIDTH'(1));
                  if (pending_d == '0) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: begin
               state_d   = IDLE;
               pending_d = '0;
            end
         endcase
      end
   end

   // State, pending vector and done pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         pending_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         done_q    <= done_d;
      end
   end

   assign valid_o     = emitting;
   assign busy_o      = emitting;
   assign idx_o       = emitting ? lowestIdx : '0;
   assign remaining_o = emitting ? popCount : '0;
   assign done_o      = done_q;

endmodule
